recir_lane_dist: RTL

RECIR_LANE_DIST -- requirements
Module: recir_lane_dist

---
 rtl/recir_lane_dist.sv | 99 +++++++++
 1 files changed

// File: rtl/recir_lane_dist.sv
// recir_lane_dist: round-robin word distributor over NF FIFOs; a word aimed at a full FIFO is
// held and retried (RECIRC) until that FIFO frees, and a run of IDLE_RUN idle words parks the block.
module recir_lane_dist #(
  parameter int BW = 8,
  parameter int NF = 4,
  parameter logic [BW-1:0] IDLE_SYM = BW'(8'h7C),
  parameter int IDLE_RUN = 4,
  localparam int PW = $clog2(NF)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic [BW-1:0] data_in,
  input  logic          valid_in,
  input  logic [NF-1:0] fifo_full,
  output logic          in_ready,
  output logic [NF-1:0] push,
  output logic [BW-1:0] push_data,
  output logic [PW-1:0] ptr,
  output logic [1:0]    state,
  output logic          idle_flag,
  output logic [15:0]   recirc_cnt
);
  typedef enum logic [1:0] {IDLE = 2'b00, ACTIVE = 2'b01, RECIRC = 2'b10} st_t;
  localparam logic [7:0] IR = 8'(IDLE_RUN);
  st_t st_q, st_d;
  logic [PW-1:0] ptr_d, ptr_nxt;
  logic [NF-1:0] push_d, sel;
  logic [BW-1:0] pdata_d, hold, hold_d;
  logic [7:0] icnt_q, icnt_d, icnt_inc;
  logic [15:0] rcnt_d;
  logic acc, is_idle, tgt_full;
  assign state = st_q;
  assign in_ready = st_q != RECIRC;
  assign idle_flag = st_q == IDLE;
  assign acc = valid_in && in_ready;
  assign is_idle = data_in == IDLE_SYM;
  assign tgt_full = fifo_full[ptr];
  assign ptr_nxt = (ptr == PW'(NF - 1)) ? '0 : ptr + PW'(1);
  assign sel = NF'(1) << ptr;
  assign icnt_inc = (icnt_q >= IR) ? IR : icnt_q + 8'd1;
  always_comb begin
    st_d = st_q;
    ptr_d = ptr;
    push_d = '0;
    pdata_d = push_data;
    hold_d = hold;
    icnt_d = icnt_q;
    rcnt_d = recirc_cnt;
    case (st_q)
      RECIRC: begin
        if (tgt_full) rcnt_d = recirc_cnt + {15'd0, recirc_cnt != 16'hFFFF};
        else begin
          push_d = sel;
          pdata_d = hold;
          ptr_d = ptr_nxt;
          st_d = ACTIVE;
        end
      end
      IDLE, ACTIVE: begin
        if (acc && is_idle) begin
          icnt_d = icnt_inc;
          st_d = (icnt_inc == IR) ? IDLE : st_q;
          ptr_d = (icnt_inc == IR) ? '0 : ptr;
        end else if (acc) begin
          icnt_d = '0;
          if (tgt_full) begin
            hold_d = data_in;
            st_d = RECIRC;
          end else begin
            push_d = sel;
            pdata_d = data_in;
            ptr_d = ptr_nxt;
            st_d = ACTIVE;
          end
        end
      end
      default: st_d = IDLE;
    endcase
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      st_q <= IDLE;
      ptr <= '0;
      push <= '0;
      push_data <= '0;
      hold <= '0;
      icnt_q <= '0;
      recirc_cnt <= '0;
    end else begin
      st_q <= st_d;
      ptr <= ptr_d;
      push <= push_d;
      push_data <= pdata_d;
      hold <= hold_d;
      icnt_q <= icnt_d;
      recirc_cnt <= rcnt_d;
    end
  end
endmodule
